hamming_encoder_pipe: RTL and testbench

Parametrised, pipelined Hamming encoder for the transceiver TX path. It accepts DATA_W-bit words over a valid/ready handshake and emits single-error-correcting codewords, with an optional SEC-DED overall parity bit. It adds a per-word error-injection mask for link testing and a delivered-codeword counter. It replaces the fixed 8-bit, write-enable-strobed encoder between the framer and the serializer.

---
 rtl/hamming_pkg.sv | 57 +++++
 rtl/hamming_parity_gen.sv | 18 +
 rtl/hamming_encoder_pipe.sv | 97 +++++++++
 tb/tb_hamming_encoder_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming code geometry helpers for the encoder and the future decoder.
// All functions are constant-foldable so they can size ports and generate loops.
package hamming_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_POS    = 128;

    // Smallest r with 2^r >= data_w + r + 1; the descending scan keeps the smallest hit.
    function automatic int calc_r(input int data_w);
        int r;
        r = 0;
        for (int i = 7; i >= 1; i--) begin
            if ((1 << i) >= data_w + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic int code_w(input int data_w, input int secded);
        return data_w + calc_r(data_w) + ((secded != 0) ? 1 : 0);
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position (1-based) of data bit j: the j-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < MAX_POS; p++) begin
            if (!is_pow2(p)) begin
                if (n == j && pos == 0) begin
                    pos = p;
                end
                n++;
            end
        end
        return pos;
    endfunction

    // Data bits that feed parity bit p_k.
    function automatic logic [MAX_DATA_W-1:0] parity_mask(input int k, input int data_w);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int j = 0; j < data_w; j++) begin
            if (((data_pos(j) >> k) & 1) != 0) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming parity tree: DATA_W data bits in, R parity bits out.
// Zero latency, no handshake; shared with the decoder for syndrome generation.
module hamming_parity_gen
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int R = calc_r(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    output logic [R-1:0]      parity
);

    for (genvar k = 0; k < R; k++) begin : g_par
        localparam logic [MAX_DATA_W-1:0] MASK = parity_mask(k, DATA_W);
        assign parity[k] = ^(data & MASK[DATA_W-1:0]);
    end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage Hamming/SEC-DED encoder with per-word error injection and delivery counter.
// Latency 2 cycles; ready chain is combinational so a full pipe still streams 1 word/cycle.
module hamming_encoder_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SECDED = 1,
    parameter int CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int CODE_W = code_w(DATA_W, SECDED)
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CODE_W-1:0] s_inj,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CODE_W-1:0] m_code,
    output logic [CNT_W-1:0]  cnt
);

    localparam int HW = DATA_W + R;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CODE_W-1:0] s1_inj;
    logic [R-1:0]      s1_par;
    logic [R-1:0]      par_nxt;
    logic              s2_adv;
    logic [HW-1:0]     ham;
    logic [CODE_W-1:0] enc;
    logic [CODE_W-1:0] code_nxt;

    assign s2_adv  = ~m_valid | m_ready;
    assign s_ready = ~s1_valid | s2_adv;

    hamming_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .data   (s_data),
        .parity (par_nxt)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inj   <= '0;
            s1_par   <= '0;
        end else if (s_ready) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_data <= s_data;
                s1_inj  <= s_inj;
                s1_par  <= par_nxt;
            end
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_dat
        localparam int P = data_pos(j);
        assign ham[P-1] = s1_data[j];
    end

    for (genvar k = 0; k < R; k++) begin : g_chk
        assign ham[(1 << k) - 1] = s1_par[k];
    end

    // Overall parity covers the clean codeword so injected errors stay visible downstream.
    if (SECDED != 0) begin : g_secded
        assign enc = {^ham, ham};
    end else begin : g_plain
        assign enc = ham;
    end

    assign code_nxt = enc ^ s1_inj;

    // m_code returns to zero whenever the output slot empties.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_valid <= 1'b0;
            m_code  <= '0;
        end else if (s2_adv) begin
            m_valid <= s1_valid;
            m_code  <= s1_valid ? code_nxt : '0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
        end else if (m_valid && m_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Directed bench: 8-bit plain and SEC-DED instances share stimulus; a 32-bit instance uses a reference model.
module tb_hamming_encoder_pipe;

    logic        clk = 1'b0;
    logic        arstn;

    logic        s_valid;
    logic        m_ready;
    logic [7:0]  s_data;
    logic [12:0] s_inj;
    logic        s_ready0, s_ready1, m_valid0, m_valid1;
    logic [11:0] m_code0;
    logic [12:0] m_code1;
    logic [15:0] cnt0, cnt1;

    logic        v2, r2, mv2, mr2;
    logic [31:0] d2;
    logic [38:0] inj2, mc2;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_encoder_pipe #(.DATA_W(8), .SECDED(0), .CNT_W(16)) u0 (
        .clk(clk), .arstn(arstn), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .s_inj(s_inj[11:0]), .m_valid(m_valid0), .m_ready(m_ready), .m_code(m_code0), .cnt(cnt0)
    );

    hamming_encoder_pipe #(.DATA_W(8), .SECDED(1), .CNT_W(16)) u1 (
        .clk(clk), .arstn(arstn), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .s_inj(s_inj), .m_valid(m_valid1), .m_ready(m_ready), .m_code(m_code1), .cnt(cnt1)
    );

    hamming_encoder_pipe #(.DATA_W(32), .SECDED(1), .CNT_W(4)) u2 (
        .clk(clk), .arstn(arstn), .s_valid(v2), .s_ready(r2), .s_data(d2),
        .s_inj(inj2), .m_valid(mv2), .m_ready(mr2), .m_code(mc2), .cnt(cnt2)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: place data at non-power-of-two positions, then each p_k makes
    // the XOR over all positions with bit k set even.
    function automatic logic [71:0] ref_ham(input logic [63:0] d, input int dw);
        logic [71:0] c;
        logic        x;
        int          r, j, hw;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        hw = dw + r;
        c  = '0;
        j  = 0;
        for (int p = 1; p <= hw; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < r; k++) begin
            x = 1'b0;
            for (int p = 1; p <= hw; p++) begin
                if (((p >> k) & 1) == 1 && p != (1 << k)) x ^= c[p-1];
            end
            c[(1 << k) - 1] = x;
        end
        return c;
    endfunction

    function automatic logic [12:0] enc8(input logic [7:0] d);
        logic [71:0] h;
        h = ref_ham({56'b0, d}, 8);
        return {^h[11:0], h[11:0]};
    endfunction

    function automatic logic [38:0] enc32(input logic [31:0] d);
        logic [71:0] h;
        h = ref_ham({32'b0, d}, 32);
        return {^h[37:0], h[37:0]};
    endfunction

    typedef struct {
        logic [7:0]  d;
        logic [12:0] inj;
        logic [11:0] e0;
        logic [12:0] e1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          sent, got, infl;
        logic        acc, dlv, hold_chk;
        logic [12:0] held;
        logic [31:0] pat;
        logic [38:0] q2 [$];

        tbl[0] = '{8'h00, 13'h0000, 12'h000, 13'h0000};
        tbl[1] = '{8'hFF, 13'h0000, 12'hF77, 13'h0F77};
        tbl[2] = '{8'h01, 13'h0000, 12'h007, 13'h1007};
        tbl[3] = '{8'h01, 13'h0010, 12'h017, 13'h1017};
        tbl[4] = '{8'h01, 13'h0030, 12'h037, 13'h1037};
        tbl[5] = '{8'h80, 13'h0000, 12'h888, 13'h1888};
        tbl[6] = '{8'h00, 13'h1000, 12'h000, 13'h1000};

        arstn   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        s_inj   = '0;
        v2      = 1'b0;
        mr2     = 1'b0;
        d2      = '0;
        inj2    = '0;

        #2;
        chk("rst_s_ready", s_ready1, 1'b1);
        chk("rst_m_valid", m_valid1, 1'b0);
        chk("rst_m_code", m_code1, 13'h0);
        chk("rst_cnt", cnt1, 16'h0);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tbl[i].d;
            s_inj   = tbl[i].inj;
            m_ready = 1'b1;
            #1;
            chk("tbl_s_ready", s_ready1, 1'b1);
            @(negedge clk);
            s_valid = 1'b0;
            chk("tbl_latency", m_valid1, 1'b0);
            @(negedge clk);
            chk("tbl_m_valid", m_valid0, 1'b1);
            chk("tbl_code_plain", m_code0, tbl[i].e0);
            chk("tbl_code_secded", m_code1, tbl[i].e1);
            @(negedge clk);
            chk("tbl_idle_zero", m_code1, 13'h0);
        end
        chk("tbl_cnt", cnt0, 16'd7);

        // Back-pressure stream 0x01..0x10 with a fixed stall pattern.
        pat      = 32'hC38E_31F0;
        sent     = 0;
        got      = 0;
        infl     = 0;
        hold_chk = 1'b0;
        held     = '0;
        s_inj    = '0;
        for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
            @(negedge clk);
            m_ready = pat[cyc % 32];
            s_valid = (sent < 16);
            s_data  = 8'(sent + 1);
            #1;
            if (hold_chk) begin
                chk("bp_hold_valid", m_valid1, 1'b1);
                chk("bp_hold_code", m_code1, held);
            end
            chk("bp_s_ready", s_ready1, !(infl == 2 && !m_ready));
            acc = s_valid && s_ready1;
            dlv = m_valid1 && m_ready;
            if (dlv) begin
                chk("bp_code", m_code1, enc8(8'(got + 1)));
                got++;
                infl--;
            end
            hold_chk = m_valid1 && !m_ready;
            held     = m_code1;
            if (acc) begin
                sent++;
                infl++;
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("bp_delivered", got, 16);
        chk("bp_cnt", cnt1, 16'd23);

        // Fill both stages, then reset mid-stream.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        @(negedge clk);
        s_data  = 8'h5A;
        @(negedge clk);
        #1;
        chk("full_s_ready", s_ready1, 1'b0);
        chk("full_m_valid", m_valid1, 1'b1);
        s_valid = 1'b0;
        #1;
        arstn = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid1, 1'b0);
        chk("midrst_m_code", m_code1, 13'h0);
        chk("midrst_cnt", cnt1, 16'h0);
        chk("midrst_s_ready", s_ready1, 1'b1);
        @(negedge clk);
        arstn   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", m_valid1, 1'b0);
        end
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_code", m_code1, 13'h0F77);
        chk("post_rst_cnt0", cnt1, 16'h0);
        @(negedge clk);
        chk("post_rst_cnt1", cnt1, 16'h1);

        // 32-bit SEC-DED with a 4-bit counter: 17 deliveries wrap to 1.
        sent = 0;
        got  = 0;
        chk("w32_cnt_start", cnt2, 4'h0);
        for (int cyc = 0; cyc < 80 && got < 17; cyc++) begin
            @(negedge clk);
            mr2 = 1'b1;
            v2  = (sent < 17);
            d2  = $urandom;
            #1;
            if (mv2) begin
                chk("w32_code", mc2, (q2.size() > 0) ? q2.pop_front() : 39'h0);
                got++;
            end
            if (v2 && r2) begin
                q2.push_back(enc32(d2));
                sent++;
            end
        end
        v2 = 1'b0;
        @(negedge clk);
        chk("w32_delivered", got, 17);
        chk("w32_cnt_wrap", cnt2, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
